// File: rtl/apb_chk_pkg.sv
// Shared types for the APB3 protocol checker: FSM states, error codes and the
// captured transfer record (sized for the widest supported bus, zero-extended).
package apb_chk_pkg;

    localparam int unsigned MAX_ADDR_W = 64;
    localparam int unsigned MAX_DATA_W = 64;
    localparam int unsigned MAX_SLAVES = 32;
    localparam int unsigned NUM_CODES  = 5;
    localparam int unsigned CODE_W     = 3;
    localparam int unsigned COUNT_W    = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    typedef enum logic [CODE_W-1:0] {
        ERR_NONE            = 3'd0,
        ERR_PSEL_MULTI      = 3'd1,
        ERR_ENABLE_NO_SETUP = 3'd2,
        ERR_SETUP_NO_ACCESS = 3'd3,
        ERR_CTRL_CHANGED    = 3'd4,
        ERR_TIMEOUT         = 3'd5
    } err_code_e;

    typedef struct packed {
        logic                  write;
        logic [MAX_ADDR_W-1:0] addr;
        logic [MAX_SLAVES-1:0] sel;
        logic [MAX_DATA_W-1:0] data;
    } xfer_rec_t;

endpackage

// File: rtl/apb_protocol_checker.sv
// Passive APB3 monitor: tracks IDLE/ACCESS, flags protocol violations and
// reports each completed transfer with its wait-state count.
module apb_protocol_checker
    import apb_chk_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned WAIT_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] Paddr,
    input  logic                  Pwrite,
    input  logic [NUM_SLAVES-1:0] Pselx,
    input  logic                  Penable,
    input  logic [DATA_WIDTH-1:0] Pwdata,
    input  logic [DATA_WIDTH-1:0] Prdata,
    input  logic                  Pready,
    input  logic                  Pslverr,
    input  logic                  clear_err,
    output logic                  err_valid,
    output logic [CODE_W-1:0]     err_code,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [NUM_CODES-1:0]  err_sticky,
    output logic [COUNT_W-1:0]    err_count,
    output logic                  xfer_done,
    output logic                  xfer_write,
    output logic [ADDR_WIDTH-1:0] xfer_addr,
    output logic [DATA_WIDTH-1:0] xfer_data,
    output logic [NUM_SLAVES-1:0] xfer_sel,
    output logic                  xfer_slverr,
    output logic [WAIT_WIDTH-1:0] xfer_wait
);

    function automatic logic multi_sel(input logic [NUM_SLAVES-1:0] sel);
        return (sel & (sel - NUM_SLAVES'(1))) != '0;
    endfunction

    state_e                state_q, state_d;
    xfer_rec_t             cap_q, cap_d, cur_c;
    logic [WAIT_WIDTH-1:0] wait_q, wait_d, wait_inc_c;
    logic [NUM_CODES-1:0]  hit_c;
    logic                  done_c;
    logic                  ctrl_diff_c;
    err_code_e             code_c;

    // Current bus control, zero-extended to the record layout
    always_comb begin
        cur_c       = '0;
        cur_c.write = Pwrite;
        cur_c.addr  = MAX_ADDR_W'(Paddr);
        cur_c.sel   = MAX_SLAVES'(Pselx);
        cur_c.data  = MAX_DATA_W'(Pwdata);
        ctrl_diff_c = (cur_c.write != cap_q.write) || (cur_c.addr != cap_q.addr) ||
                      (cur_c.sel != cap_q.sel) ||
                      (cap_q.write && (cur_c.data != cap_q.data));
    end

    // Next state, detected error set and completion strobe
    always_comb begin
        state_d    = state_q;
        cap_d      = cap_q;
        wait_d     = wait_q;
        wait_inc_c = wait_q + WAIT_WIDTH'(1);
        hit_c      = '0;
        done_c     = 1'b0;
        code_c     = ERR_NONE;

        hit_c[0] = multi_sel(Pselx);

        case (state_q)
            IDLE: begin
                if (Penable) begin
                    hit_c[1] = 1'b1;
                end else if (|Pselx) begin
                    cap_d   = cur_c;
                    wait_d  = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!Penable) begin
                    hit_c[2] = 1'b1;
                    if (|Pselx) begin
                        cap_d  = cur_c;
                        wait_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (ctrl_diff_c) begin
                    hit_c[3] = 1'b1;
                    state_d  = IDLE;
                end else if (Pready) begin
                    done_c  = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_inc_c;
                    if ((TIMEOUT != 0) && (wait_inc_c == WAIT_WIDTH'(TIMEOUT))) begin
                        hit_c[4] = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Lowest detected code wins
        for (int i = int'(NUM_CODES) - 1; i >= 0; i--) begin
            if (hit_c[i]) code_c = err_code_e'(CODE_W'(i + 1));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cap_q       <= '0;
            wait_q      <= '0;
            err_valid   <= 1'b0;
            err_code    <= '0;
            err_addr    <= '0;
            err_sticky  <= '0;
            err_count   <= '0;
            xfer_done   <= 1'b0;
            xfer_write  <= 1'b0;
            xfer_addr   <= '0;
            xfer_data   <= '0;
            xfer_sel    <= '0;
            xfer_slverr <= 1'b0;
            xfer_wait   <= '0;
        end else begin
            state_q   <= state_d;
            cap_q     <= cap_d;
            wait_q    <= wait_d;
            err_valid <= |hit_c;
            err_code  <= code_c;
            err_addr  <= (|hit_c) ? Paddr : '0;
            if (clear_err) begin
                err_sticky <= '0;
                err_count  <= '0;
            end else begin
                err_sticky <= err_sticky | hit_c;
                if ((|hit_c) && (err_count != {COUNT_W{1'b1}}))
                    err_count <= err_count + COUNT_W'(1);
            end
            xfer_done <= done_c;
            if (done_c) begin
                xfer_write  <= cap_q.write;
                xfer_addr   <= ADDR_WIDTH'(cap_q.addr);
                xfer_sel    <= NUM_SLAVES'(cap_q.sel);
                xfer_data   <= cap_q.write ? Pwdata : Prdata;
                xfer_slverr <= Pslverr;
                xfer_wait   <= wait_q;
            end
        end
    end

endmodule

// File: tb/tb_apb_protocol_checker.sv
// Directed and randomized bench for apb_protocol_checker against a
// transfer-level reference model.
module tb_apb_protocol_checker;

    localparam int TIMEOUT = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] Paddr;
    logic        Pwrite;
    logic [3:0]  Pselx;
    logic        Penable;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        Pready;
    logic        Pslverr;
    logic        clear_err;
    logic        err_valid;
    logic [2:0]  err_code;
    logic [31:0] err_addr;
    logic [4:0]  err_sticky;
    logic [15:0] err_count;
    logic        xfer_done;
    logic        xfer_write;
    logic [31:0] xfer_addr;
    logic [31:0] xfer_data;
    logic [3:0]  xfer_sel;
    logic        xfer_slverr;
    logic [7:0]  xfer_wait;

    apb_protocol_checker #(
        .NUM_SLAVES(4), .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .TIMEOUT(TIMEOUT), .WAIT_WIDTH(8)
    ) dut (
        .clock(clock), .reset(reset), .Paddr(Paddr), .Pwrite(Pwrite),
        .Pselx(Pselx), .Penable(Penable), .Pwdata(Pwdata), .Prdata(Prdata),
        .Pready(Pready), .Pslverr(Pslverr), .clear_err(clear_err),
        .err_valid(err_valid), .err_code(err_code), .err_addr(err_addr),
        .err_sticky(err_sticky), .err_count(err_count), .xfer_done(xfer_done),
        .xfer_write(xfer_write), .xfer_addr(xfer_addr), .xfer_data(xfer_data),
        .xfer_sel(xfer_sel), .xfer_slverr(xfer_slverr), .xfer_wait(xfer_wait)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: an outstanding-transfer flag plus captured control
    bit          m_pending;
    logic [31:0] m_addr, m_wdata;
    logic        m_write;
    logic [3:0]  m_sel;
    int          m_wait;

    logic        e_err_valid, e_done, e_xwrite, e_xslverr;
    logic [2:0]  e_err_code;
    logic [31:0] e_err_addr, e_xaddr, e_xdata;
    logic [4:0]  e_sticky;
    int          e_count;
    logic [3:0]  e_xsel;
    logic [7:0]  e_xwait;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic capture();
        m_pending = 1'b1;
        m_addr    = Paddr;
        m_write   = Pwrite;
        m_sel     = Pselx;
        m_wdata   = Pwdata;
        m_wait    = 0;
    endtask

    task automatic model_step();
        bit [4:0] hit;
        int       code;
        hit = '0;
        if (reset) begin
            m_pending = 1'b0; m_wait = 0;
            e_err_valid = 0; e_err_code = 0; e_err_addr = 0; e_sticky = 0; e_count = 0;
            e_done = 0; e_xwrite = 0; e_xaddr = 0; e_xdata = 0; e_xsel = 0;
            e_xslverr = 0; e_xwait = 0;
        end else begin
            if ($countones(Pselx) > 1) hit[0] = 1'b1;
            e_done = 1'b0;
            if (!m_pending) begin
                if (Penable) hit[1] = 1'b1;
                else if (Pselx != 4'd0) capture();
            end else if (!Penable) begin
                hit[2] = 1'b1;
                if (Pselx != 4'd0) capture();
                else m_pending = 1'b0;
            end else if (Paddr != m_addr || Pwrite != m_write || Pselx != m_sel ||
                         (m_write && Pwdata != m_wdata)) begin
                hit[3] = 1'b1;
                m_pending = 1'b0;
            end else if (Pready) begin
                e_done    = 1'b1;
                e_xwrite  = m_write;
                e_xaddr   = m_addr;
                e_xsel    = m_sel;
                e_xdata   = m_write ? Pwdata : Prdata;
                e_xslverr = Pslverr;
                e_xwait   = 8'(m_wait);
                m_pending = 1'b0;
            end else begin
                m_wait++;
                if (TIMEOUT != 0 && m_wait == TIMEOUT) begin
                    hit[4] = 1'b1;
                    m_pending = 1'b0;
                end
            end
            code = 0;
            for (int c = 1; c <= 5; c++) if (hit[c-1] && code == 0) code = c;
            e_err_valid = (hit != 0);
            e_err_code  = 3'(code);
            e_err_addr  = (hit != 0) ? Paddr : 32'd0;
            if (clear_err) begin
                e_sticky = 0;
                e_count  = 0;
            end else begin
                e_sticky = e_sticky | hit;
                if (hit != 0 && e_count < 65535) e_count++;
            end
        end
    endtask

    task automatic check_all();
        chk("err_valid", 64'(err_valid), 64'(e_err_valid));
        chk("err_code", 64'(err_code), 64'(e_err_code));
        chk("err_addr", 64'(err_addr), 64'(e_err_addr));
        chk("err_sticky", 64'(err_sticky), 64'(e_sticky));
        chk("err_count", 64'(err_count), 64'(e_count));
        chk("xfer_done", 64'(xfer_done), 64'(e_done));
        if (e_done) begin
            chk("xfer_write", 64'(xfer_write), 64'(e_xwrite));
            chk("xfer_addr", 64'(xfer_addr), 64'(e_xaddr));
            chk("xfer_data", 64'(xfer_data), 64'(e_xdata));
            chk("xfer_sel", 64'(xfer_sel), 64'(e_xsel));
            chk("xfer_slverr", 64'(xfer_slverr), 64'(e_xslverr));
            chk("xfer_wait", 64'(xfer_wait), 64'(e_xwait));
        end
    endtask

    task automatic step(input bit do_check);
        model_step();
        @(posedge clock);
        #1;
        if (do_check) check_all();
    endtask

    task automatic drive(input logic [3:0] s, input logic en, input logic [31:0] a,
                         input logic w, input logic [31:0] wd, input logic rdy,
                         input logic [31:0] rd, input logic se);
        Pselx = s; Penable = en; Paddr = a; Pwrite = w; Pwdata = wd;
        Pready = rdy; Prdata = rd; Pslverr = se;
    endtask

    initial begin
        logic [3:0]  rs;
        logic [31:0] ra, rw;
        logic        rwr;
        int          waits, f;

        reset = 1'b1; clear_err = 1'b0;
        drive(4'd0, 0, 32'd0, 0, 32'd0, 0, 32'd0, 0);
        step(1); step(1);
        chk("reset_count", 64'(err_count), 64'd0);
        chk("reset_done", 64'(xfer_done), 64'd0);
        reset = 1'b0;

        // Zero-wait write
        drive(4'b0010, 0, 32'h10, 1, 32'h1234, 0, 32'd0, 0); step(1);
        drive(4'b0010, 1, 32'h10, 1, 32'h1234, 1, 32'd0, 0); step(1);
        chk("wr_done", 64'(xfer_done), 64'd1);
        chk("wr_wait", 64'(xfer_wait), 64'd0);
        chk("wr_write", 64'(xfer_write), 64'd1);
        chk("wr_addr", 64'(xfer_addr), 64'h10);
        chk("wr_noerr", 64'(err_valid), 64'd0);

        // Read with three wait states and a slave error response
        drive(4'd0, 0, 32'd0, 0, 32'd0, 0, 32'd0, 0); step(1);
        drive(4'b0001, 0, 32'h20, 0, 32'd0, 0, 32'd0, 0); step(1);
        for (int k = 0; k < 3; k++) begin
            drive(4'b0001, 1, 32'h20, 0, 32'd0, 0, 32'd0, 0); step(1);
        end
        drive(4'b0001, 1, 32'h20, 0, 32'd0, 1, 32'hCAFE, 1); step(1);
        chk("rd_done", 64'(xfer_done), 64'd1);
        chk("rd_wait", 64'(xfer_wait), 64'd3);
        chk("rd_data", 64'(xfer_data), 64'hCAFE);
        chk("rd_slverr", 64'(xfer_slverr), 64'd1);
        chk("rd_count", 64'(err_count), 64'd0);

        // Timeout after 16 wait cycles, then FSM is back in IDLE
        drive(4'b1000, 0, 32'h30, 1, 32'hAA, 0, 32'd0, 0); step(1);
        for (int k = 0; k < TIMEOUT; k++) begin
            drive(4'b1000, 1, 32'h30, 1, 32'hAA, 0, 32'd0, 0); step(1);
        end
        chk("to_valid", 64'(err_valid), 64'd1);
        chk("to_code", 64'(err_code), 64'd5);
        chk("to_sticky", 64'(err_sticky), 64'b10000);
        step(1);
        chk("to_idle_code", 64'(err_code), 64'd2);
        drive(4'd0, 0, 32'd0, 0, 32'd0, 0, 32'd0, 0); clear_err = 1'b1; step(1);
        clear_err = 1'b0;
        chk("clr1_sticky", 64'(err_sticky), 64'd0);

        // Multi-select together with an address change in ACCESS
        drive(4'b0010, 0, 32'h40, 0, 32'd0, 0, 32'd0, 0); step(1);
        drive(4'b0110, 1, 32'h44, 0, 32'd0, 1, 32'd0, 0); step(1);
        chk("multi_code", 64'(err_code), 64'd1);
        chk("multi_sticky", 64'(err_sticky), 64'b01001);
        chk("multi_count", 64'(err_count), 64'd1);
        chk("multi_nodone", 64'(xfer_done), 64'd0);
        drive(4'd0, 0, 32'd0, 0, 32'd0, 0, 32'd0, 0); clear_err = 1'b1; step(1);
        clear_err = 1'b0;

        // Penable lingering after completion, then Penable without setup
        drive(4'b0100, 0, 32'h50, 1, 32'h5, 0, 32'd0, 0); step(1);
        drive(4'b0100, 1, 32'h50, 1, 32'h5, 1, 32'd0, 0); step(1);
        chk("b2b_done", 64'(xfer_done), 64'd1);
        step(1);
        chk("linger_code", 64'(err_code), 64'd2);
        drive(4'd0, 0, 32'd0, 0, 32'd0, 0, 32'd0, 0); step(1);
        drive(4'd0, 1, 32'h60, 0, 32'd0, 0, 32'd0, 0); step(1);
        chk("nosetup_code", 64'(err_code), 64'd2);
        chk("nosetup_addr", 64'(err_addr), 64'h60);
        chk("nosetup_count", 64'(err_count), 64'd2);

        // Saturate the error counter
        drive(4'd0, 0, 32'd0, 0, 32'd0, 0, 32'd0, 0); clear_err = 1'b1; step(1);
        clear_err = 1'b0;
        drive(4'd0, 1, 32'd0, 0, 32'd0, 0, 32'd0, 0);
        for (int k = 0; k < 65535; k++) step(0);
        chk("sat_reach", 64'(err_count), 64'hFFFF);
        step(1);
        chk("sat_hold", 64'(err_count), 64'hFFFF);
        chk("sat_valid", 64'(err_valid), 64'd1);
        drive(4'd0, 0, 32'd0, 0, 32'd0, 0, 32'd0, 0); clear_err = 1'b1; step(1);
        clear_err = 1'b0;
        chk("clr_count", 64'(err_count), 64'd0);
        chk("clr_sticky", 64'(err_sticky), 64'd0);

        // Reset in the middle of an access phase
        drive(4'b0001, 0, 32'h70, 0, 32'd0, 0, 32'd0, 0); step(1);
        drive(4'b0001, 1, 32'h70, 0, 32'd0, 0, 32'd0, 0); step(1);
        reset = 1'b1;
        drive(4'b0001, 1, 32'h70, 0, 32'd0, 1, 32'h99, 0); step(1);
        chk("rst_done", 64'(xfer_done), 64'd0);
        chk("rst_valid", 64'(err_valid), 64'd0);
        chk("rst_xaddr", 64'(xfer_addr), 64'd0);
        reset = 1'b0;
        drive(4'd0, 1, 32'h74, 0, 32'd0, 0, 32'd0, 0); step(1);
        chk("post_rst_code", 64'(err_code), 64'd2);

        // Randomized transfers with occasional protocol faults
        for (int t = 0; t < 250; t++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                drive(4'd0, 0, $urandom, 0, $urandom, 0, $urandom, 0);
                clear_err = ($urandom_range(0, 19) == 0); reset = 1'b0; step(1);
            end
            rs = 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) rs = rs | 4'(1 << $urandom_range(0, 3));
            ra = $urandom & 32'hFFFC; rw = $urandom; rwr = 1'($urandom);
            clear_err = 1'b0; reset = 1'b0;
            drive(rs, 0, ra, rwr, rw, 1'($urandom), $urandom, 0); step(1);
            waits = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 20))
                                                 : int'($urandom_range(0, 4));
            for (int w = 0; w <= waits; w++) begin
                drive(rs, 1, ra, rwr, rw, (w == waits), $urandom, 1'($urandom));
                f = int'($urandom_range(0, 29));
                if (f == 0) Penable = 1'b0;
                if (f == 1) Paddr = ra ^ 32'h4;
                if (f == 2) Pwdata = rw ^ 32'h1;
                if (f == 3) Pwrite = ~rwr;
                clear_err = ($urandom_range(0, 19) == 0);
                reset = ($urandom_range(0, 199) == 0);
                step(1);
            end
        end
        reset = 1'b0; clear_err = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_protocol_checker.md
# apb_protocol_checker

Synthesizable APB3 protocol checker sitting passively on the APB side of the AHB-to-APB bridge, one instance per APB bus. It tracks each transfer through IDLE/SETUP/ACCESS and handles any slave count and bus width. It also supports wait states (Pready) and slave errors (Pslverr), which a single-slave fixed-width checker does not. It reports protocol violations as coded error pulses with sticky flags and a saturating count, and reports completed transfers, with their wait-state count, to the scoreboard and coverage.

## Interface
- NUM_SLAVES, 4: width of Pselx.
- ADDR_WIDTH, 32: Paddr width.
- DATA_WIDTH, 32: Pwdata/Prdata width.
- TIMEOUT, 16: maximum wait cycles in ACCESS before error. 0 disables the timeout.
- WAIT_WIDTH, 8: width of the wait counter and xfer_wait. Must satisfy TIMEOUT < 2**WAIT_WIDTH.

Ports:
- clock  in  1  single clock; all bus sampling on posedge.
- reset  in  1  synchronous, active-high.
- Paddr  in  ADDR_WIDTH  APB address.
- Pwrite  in  1  APB direction.
- Pselx  in  NUM_SLAVES  APB slave selects.
- Penable  in  1  APB enable.
- Pwdata  in  DATA_WIDTH  APB write data.
- Prdata  in  DATA_WIDTH  APB read data.
- Pready  in  1  slave ready.
- Pslverr  in  1  slave error response.
- clear_err  in  1  pulse; clears err_sticky and err_count.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  3  code of the reported error.
- err_addr  out  ADDR_WIDTH  Paddr sampled on the error cycle.
- err_sticky  out  5  bit (code-1) set per error seen.
- err_count  out  16  saturating error count.
- xfer_done  out  1  one-cycle completion pulse.
- xfer_write, xfer_addr, xfer_data, xfer_sel, xfer_slverr, xfer_wait  out  1/ADDR/DATA/NUM_SLAVES/1/WAIT_WIDTH  completed transfer record.

## Operation
- Error codes:
  - 1 PSEL_MULTI: more than one Pselx bit high. Checked every cycle, independent of state.
  - 2 ENABLE_NO_SETUP: Penable=1 sampled in IDLE.
  - 3 SETUP_NO_ACCESS: in ACCESS, Penable=0.
  - 4 CTRL_CHANGED: in ACCESS, Paddr, Pwrite or Pselx differs from the captured value. On writes, Pwdata differing from the captured value also counts.
  - 5 TIMEOUT: wait count reaches TIMEOUT.
- Several errors in one cycle: the lowest code is reported in err_code. Every detected code sets its own sticky bit. err_count increments by 1 per error cycle.
- FSM states are IDLE and ACCESS. ACCESS means a setup was sampled and an access phase is expected.
- IDLE:
  - Penable=1 raises error 2 and the FSM stays in IDLE.
  - |Pselx && !Penable is a setup: capture Paddr, Pwrite, Pselx and Pwdata, clear the wait count, go to ACCESS.
- ACCESS, checked in this order:
  - Penable=0 raises error 3. If |Pselx, the cycle is treated as a fresh setup (recapture, stay in ACCESS); otherwise go to IDLE.
  - A control mismatch raises error 4 and the FSM goes to IDLE.
  - Pready=1 completes the transfer:
    - xfer_done=1 with the captured fields.
    - xfer_data = Pwdata if write, Prdata if read.
    - xfer_slverr = Pslverr. Pslverr is not a protocol error.
    - xfer_wait = wait count.
    - Go to IDLE.
  - Pready=0 increments the wait count. If TIMEOUT≠0 and the incremented count equals TIMEOUT, raise error 5 and go to IDLE.
- After a completion, the FSM returns to IDLE. Penable still high on the next cycle therefore flags error 2.
- Back-to-back transfers (a setup immediately after a completion) are legal.
- clear_err takes priority over a same-cycle error: counters and sticky bits clear, but err_valid still pulses.
- err_count saturates at 16'hFFFF.

## Timing
- All outputs are registered. The sample taken at posedge N appears on the outputs after posedge N, i.e. 1-cycle latency.
- err_valid and xfer_done are single-cycle pulses. They may coincide only with code 1, when a transfer completes while PSEL_MULTI is also detected.
- Reset values: state IDLE; wait count 0; all outputs 0. reset wins over clear_err and over all bus activity.
- Reset mid-transfer abandons the transfer with no xfer_done and no error. Penable=1 on the first cycle after reset flags error 2.
- Minimum transfer: setup cycle plus one access cycle, giving xfer_done one cycle after the access edge with xfer_wait=0.

## Structure
- Package apb_chk_pkg holds:
  - state_e {IDLE, ACCESS};
  - err_code_e {ERR_NONE=0, ERR_PSEL_MULTI=1, ERR_ENABLE_NO_SETUP=2, ERR_SETUP_NO_ACCESS=3, ERR_CTRL_CHANGED=4, ERR_TIMEOUT=5};
  - a packed struct for the transfer record.
- Single module; no sub-module. The one-hot check is a local function.

## Test plan
- Write 0x10, Pselx=4'b0010, Pready=1 on the first access cycle -> xfer_done=1, xfer_wait=0, xfer_write=1, xfer_addr=0x10, no err_valid.
- Read with 3 Pready=0 cycles, then Prdata=0xCAFE with Pslverr=1 -> xfer_wait=3, xfer_data=0xCAFE, xfer_slverr=1, err_count=0.
- Pready held 0 with TIMEOUT=16 -> err_code=5 on the 16th wait cycle, err_sticky=5'b10000, FSM returns to IDLE.
- Pselx=4'b0110 together with Paddr changing mid-ACCESS -> err_code=1, err_sticky=5'b01001, err_count=1.
- Penable held high for 2 cycles after completion -> err_code=2; Penable=1 with no prior setup -> err_code=2; err_count=2.
- err_count forced to 0xFFFF, then another error -> stays 0xFFFF; clear_err -> 0 with err_sticky=0; reset during ACCESS -> all outputs 0, no xfer_done.
